crc_frame_check: RTL and testbench
==================================

Name: crc_frame_check

Overview:
- Receive-side counterpart of the CRC generator. It takes a byte stream framed by sop/eop whose last CRC_SIZE/8 bytes are the transmitted CRC field.
- Strips the CRC field and forwards the payload downstream with valid/ready.
- Recomputes the CRC over the payload and reports pass/fail, length and abort status per frame.
- Sits between the optical link deframer and the packet consumer.

Parameters:
- POLY, 16'h8005: generator polynomial, implicit top bit, width 64.
- CRC_SIZE, 16: CRC width; multiple of 8, range 8..64.
- INIT, 16'h0000: CRC register start value.
- REF_IN, 1: reflect input bytes (LSB first).
- REF_OUT, 1: reflected register/output.
- XOR_OUT, 16'hffff: final XOR before compare.
- FIELD_LE, 1: CRC field transmitted least-significant byte first.
- LEN_W, 16: payload length counter width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- soft_reset_i  in  1  synchronous frame abort, no status
- s_valid_i  in  1  input byte valid
- s_ready_o  out  1  input ready
- s_data_i  in  8  input byte
- s_sop_i  in  1  first byte of frame
- s_eop_i  in  1  last byte of frame (last CRC byte)
- m_valid_o  out  1  payload byte valid
- m_ready_i  in  1  downstream ready
- m_data_o  out  8  payload byte
- m_last_o  out  1  last payload byte
- status_valid_o  out  1  one-cycle status pulse
- crc_ok_o  out  1  frame CRC matched
- len_err_o  out  1  frame not longer than CRC_BYTES
- abort_o  out  1  frame terminated by a new sop
- frame_len_o  out  LEN_W  payload byte count, saturating

Behaviour:
- CRC_BYTES = CRC_SIZE/8. A beat is accepted when s_valid_i && s_ready_o.
- s_ready_o = !m_valid_o || m_ready_i. This is a registered output stage with no skid buffer.
- FSM states:
  - IDLE: beats without sop are dropped. A sop beat goes to FILL, CRC=INIT, count=1, byte goes into the delay line.
  - FILL: collects bytes until the delay line holds CRC_BYTES bytes, then goes to STREAM.
  - STREAM: each accepted byte pushes into the delay line. The popped oldest byte is registered onto m_data_o (1-cycle latency) and folded into the CRC.
- eop accepted in STREAM:
  - Last popped byte is output with m_last_o=1.
  - final = crc_next ^ XOR_OUT.
  - Received field = remaining CRC_BYTES-1 line bytes plus the eop byte, assembled per FIELD_LE.
  - Next cycle: status_valid_o=1, crc_ok_o=(final==field), frame_len_o = payload count. Return to IDLE.
- eop in IDLE (with sop) or FILL, i.e. total bytes ≤ CRC_BYTES:
  - No payload beat is emitted.
  - Next cycle: status_valid_o=1, len_err_o=1, crc_ok_o=0, frame_len_o=0.
- sop accepted while in FILL/STREAM:
  - Old frame status pulses next cycle with abort_o=1, crc_ok_o=0. The old frame gets no m_last_o and its delay-line bytes are discarded.
  - The new frame starts with this byte, going to FILL.
- status_valid_o is a one-cycle pulse with no backpressure. It coincides with the first cycle m_last_o is valid. Status fields hold until the next pulse.
- frame_len_o saturates at 2^LEN_W-1.
- soft_reset_i: FSM to IDLE, delay line emptied, CRC=INIT, no status. A pending m_valid_o beat is still delivered.
- Reset values: m_valid_o=0, m_last_o=0, m_data_o=0, status_valid_o=0, crc_ok_o=0, len_err_o=0, abort_o=0, frame_len_o=0. s_ready_o=1 after reset.
- CRC update is bit-serial per byte. REF_IN/REF_OUT semantics are identical to the team CRC generator, so a generated frame checks OK for all four combinations.

Optional Feature:
- Macro: CRC_FRAME_CHECK_STATS_EN.
- With the macro: 32-bit wrapping counters stat_good_o, stat_bad_o (CRC mismatch), stat_len_o, stat_abort_o.
  - Incremented on status_valid_o.
  - Cleared by rst_ni only.
- Without the macro: the ports and logic are absent.

Decomposition:
- Package crc_pkg:
  - FSM enum (IDLE, FILL, STREAM).
  - Function crc_bytes(CRC_SIZE).
  - Function crc_byte_step(crc, byte, POLY, REF_IN, REF_OUT), shared with the generator.
- One combinational sub-module crc_byte_update wraps crc_byte_step for CRC_SIZE up to 64.

Test Plan:
- "123456789" + C2 44, defaults (CRC-16/MAXIM), m_ready_i=1 → 9 payload beats, m_last_o on '9', crc_ok_o=1, frame_len_o=9.
- Same frame with byte 3 flipped to 0x34 → all 9 bytes forwarded, crc_ok_o=0.
- 2-byte frame (sop+eop on byte 2), then 1-byte frame with sop=eop → two status pulses, len_err_o=1, no m_valid_o.
- m_ready_i toggled 50% during the good frame → identical payload order and status, s_ready_o never high while the output stage is full and stalled.
- sop mid-frame after 5 bytes, followed by the good frame → abort_o=1 pulse, then a crc_ok_o=1 pulse for the new frame.
- rst_ni asserted mid-STREAM, released, good frame sent → all outputs 0 during reset, next frame crc_ok_o=1. With the stats macro, stat_good_o=1.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared CRC helpers and frame-checker FSM states. The byte step is common to the
// generator and checker so both sides agree on the REF_IN/REF_OUT behaviour.
package crc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StStream
    } crc_state_e;

    function automatic int unsigned crc_bytes(input int unsigned crc_size);
        return crc_size / 8;
    endfunction

    function automatic logic [63:0] crc_mask(input int unsigned size);
        return (size >= 64) ? {64{1'b1}} : ((64'd1 << size) - 64'd1);
    endfunction

    // Bit-reverse the low `size` bits of val.
    function automatic logic [63:0] crc_reflect(input logic [63:0] val, input int unsigned size);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < int'(size)) begin
                r[i] = val[int'(size) - 1 - i];
            end
        end
        return r;
    endfunction

    // One byte through a bit-serial CRC. With ref_out the register is kept in the
    // reflected (output) domain, so it is flipped around the MSB-first core.
    function automatic logic [63:0] crc_byte_step(input logic [63:0] crc,
                                                  input logic [7:0]  data,
                                                  input logic [63:0] poly,
                                                  input int unsigned size,
                                                  input bit          ref_in,
                                                  input bit          ref_out);
        logic [63:0] mask;
        logic [63:0] c;
        logic        fb;
        mask = crc_mask(size);
        c    = crc & mask;
        if (ref_out) begin
            c = crc_reflect(c, size);
        end
        for (int i = 0; i < 8; i++) begin
            fb = c[size - 1] ^ (ref_in ? data[i] : data[7 - i]);
            c  = (c << 1) & mask;
            if (fb) begin
                c = c ^ (poly & mask);
            end
        end
        if (ref_out) begin
            c = crc_reflect(c, size);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_byte_update.sv
// Combinational single-byte CRC update for CRC widths up to 64 bits.
module crc_byte_update
    import crc_pkg::*;
#(
    parameter int unsigned CRC_SIZE = 16,
    parameter logic [63:0] POLY     = 64'h8005,
    parameter bit          REF_IN   = 1'b1,
    parameter bit          REF_OUT  = 1'b1
) (
    input  logic [CRC_SIZE-1:0] crc_i,
    input  logic [7:0]          data_i,
    output logic [CRC_SIZE-1:0] crc_o
);

    assign crc_o = CRC_SIZE'(crc_byte_step(64'(crc_i), data_i, POLY, CRC_SIZE, REF_IN, REF_OUT));

endmodule

// File: rtl/crc_frame_check.sv
// Receive-side CRC checker: strips the trailing CRC field, forwards payload, reports status.
// Optional per-outcome counters are built when CRC_FRAME_CHECK_STATS_EN is defined.
module crc_frame_check
    import crc_pkg::*;
#(
    parameter logic [63:0] POLY     = 64'h8005,
    parameter int unsigned CRC_SIZE = 16,
    parameter logic [63:0] INIT     = 64'h0000,
    parameter bit          REF_IN   = 1'b1,
    parameter bit          REF_OUT  = 1'b1,
    parameter logic [63:0] XOR_OUT  = 64'hffff,
    parameter bit          FIELD_LE = 1'b1,
    parameter int unsigned LEN_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             soft_reset_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [7:0]       s_data_i,
    input  logic             s_sop_i,
    input  logic             s_eop_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [7:0]       m_data_o,
    output logic             m_last_o,
    output logic             status_valid_o,
    output logic             crc_ok_o,
    output logic             len_err_o,
    output logic             abort_o,
`ifdef CRC_FRAME_CHECK_STATS_EN
    output logic [31:0]      stat_good_o,
    output logic [31:0]      stat_bad_o,
    output logic [31:0]      stat_len_o,
    output logic [31:0]      stat_abort_o,
`endif
    output logic [LEN_W-1:0] frame_len_o
);

    localparam int unsigned CrcBytes = crc_bytes(CRC_SIZE);
    localparam int unsigned FillW    = $clog2(CrcBytes + 1);
    // Register lives in the output domain, so a reflected register starts reflected.
    localparam logic [CRC_SIZE-1:0] CrcInit =
        CRC_SIZE'(REF_OUT ? crc_reflect(INIT, CRC_SIZE) : INIT);
    localparam logic [CRC_SIZE-1:0] XorOut = XOR_OUT[CRC_SIZE-1:0];

    crc_state_e          r_state, w_state_nxt;
    logic [7:0]          r_line [CrcBytes];
    logic [7:0]          w_line_nxt [CrcBytes];
    logic [7:0]          w_line_push [CrcBytes];
    logic [7:0]          w_rx [CrcBytes];
    logic [FillW-1:0]    r_fill, w_fill_nxt;
    logic [CRC_SIZE-1:0] r_crc, w_crc_nxt, w_crc_next, w_final, w_field;
    logic [LEN_W-1:0]    r_len, w_len_nxt, w_len_inc;

    logic                r_m_valid, w_m_valid_nxt;
    logic                r_m_last, w_m_last_nxt;
    logic [7:0]          r_m_data, w_m_data_nxt;

    logic                r_stat_valid, w_stat_valid_nxt;
    logic                r_crc_ok, w_crc_ok_nxt;
    logic                r_len_err, w_len_err_nxt;
    logic                r_abort, w_abort_nxt;
    logic [LEN_W-1:0]    r_frame_len, w_frame_len_nxt;

    logic                w_accept;
    logic                w_start;

    assign s_ready_o = !r_m_valid || m_ready_i;
    assign w_accept  = s_valid_i && s_ready_o;
    assign w_len_inc = (r_len == {LEN_W{1'b1}}) ? r_len : r_len + LEN_W'(1);
    assign w_final   = w_crc_next ^ XorOut;

    crc_byte_update #(
        .CRC_SIZE (CRC_SIZE),
        .POLY     (POLY),
        .REF_IN   (REF_IN),
        .REF_OUT  (REF_OUT)
    ) u_crc_byte_update (
        .crc_i  (r_crc),
        .data_i (r_line[0]),
        .crc_o  (w_crc_next)
    );

    // Delay line shifts toward index 0; index 0 is the oldest byte.
    always_comb begin
        for (int i = 0; i < int'(CrcBytes) - 1; i++) begin
            w_line_push[i] = r_line[i + 1];
            w_rx[i]        = r_line[i + 1];
        end
        w_line_push[CrcBytes-1] = s_data_i;
        w_rx[CrcBytes-1]        = s_data_i;
    end

    // Received field in wire order is w_rx[0..CrcBytes-1].
    always_comb begin
        w_field = '0;
        for (int k = 0; k < int'(CrcBytes); k++) begin
            if (FIELD_LE) begin
                w_field[8*k +: 8] = w_rx[k];
            end else begin
                w_field[8*(int'(CrcBytes) - 1 - k) +: 8] = w_rx[k];
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_line_nxt       = r_line;
        w_fill_nxt       = r_fill;
        w_crc_nxt        = r_crc;
        w_len_nxt        = r_len;
        w_m_valid_nxt    = r_m_valid && !m_ready_i;
        w_m_last_nxt     = r_m_last && !m_ready_i;
        w_m_data_nxt     = r_m_data;
        w_stat_valid_nxt = 1'b0;
        w_crc_ok_nxt     = r_crc_ok;
        w_len_err_nxt    = r_len_err;
        w_abort_nxt      = r_abort;
        w_frame_len_nxt  = r_frame_len;
        w_start          = 1'b0;

        if (soft_reset_i) begin
            w_state_nxt = StIdle;
            w_line_nxt  = '{default: '0};
            w_fill_nxt  = '0;
            w_crc_nxt   = CrcInit;
            w_len_nxt   = '0;
        end else if (w_accept) begin
            unique case (r_state)
                StIdle: w_start = s_sop_i;
                StFill, StStream: begin
                    if (s_sop_i) begin
                        w_stat_valid_nxt = 1'b1;
                        w_crc_ok_nxt     = 1'b0;
                        w_len_err_nxt    = 1'b0;
                        w_abort_nxt      = 1'b1;
                        w_frame_len_nxt  = r_len;
                        w_start          = 1'b1;
                    end else if (r_state == StFill) begin
                        if (s_eop_i) begin
                            w_stat_valid_nxt = 1'b1;
                            w_crc_ok_nxt     = 1'b0;
                            w_len_err_nxt    = 1'b1;
                            w_abort_nxt      = 1'b0;
                            w_frame_len_nxt  = '0;
                            w_state_nxt      = StIdle;
                            w_fill_nxt       = '0;
                        end else begin
                            w_line_nxt = w_line_push;
                            w_fill_nxt = r_fill + FillW'(1);
                            if (r_fill == FillW'(CrcBytes - 1)) begin
                                w_state_nxt = StStream;
                            end
                        end
                    end else begin
                        w_line_nxt    = w_line_push;
                        w_m_valid_nxt = 1'b1;
                        w_m_data_nxt  = r_line[0];
                        w_m_last_nxt  = s_eop_i;
                        w_crc_nxt     = w_crc_next;
                        w_len_nxt     = w_len_inc;
                        if (s_eop_i) begin
                            w_stat_valid_nxt = 1'b1;
                            w_crc_ok_nxt     = (w_final == w_field);
                            w_len_err_nxt    = 1'b0;
                            w_abort_nxt      = 1'b0;
                            w_frame_len_nxt  = w_len_inc;
                            w_state_nxt      = StIdle;
                            w_fill_nxt       = '0;
                        end
                    end
                end
                default: ;
            endcase

            // A sop+eop byte that also aborts a frame reports abort and len_err together.
            if (w_start) begin
                if (s_eop_i) begin
                    w_stat_valid_nxt = 1'b1;
                    w_crc_ok_nxt     = 1'b0;
                    w_len_err_nxt    = 1'b1;
                    if (r_state == StIdle) begin
                        w_abort_nxt     = 1'b0;
                        w_frame_len_nxt = '0;
                    end
                    w_state_nxt = StIdle;
                    w_fill_nxt  = '0;
                end else begin
                    w_line_nxt  = w_line_push;
                    w_fill_nxt  = FillW'(1);
                    w_crc_nxt   = CrcInit;
                    w_len_nxt   = '0;
                    w_state_nxt = (CrcBytes == 1) ? StStream : StFill;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= StIdle;
            r_line       <= '{default: '0};
            r_fill       <= '0;
            r_crc        <= CrcInit;
            r_len        <= '0;
            r_m_valid    <= 1'b0;
            r_m_last     <= 1'b0;
            r_m_data     <= '0;
            r_stat_valid <= 1'b0;
            r_crc_ok     <= 1'b0;
            r_len_err    <= 1'b0;
            r_abort      <= 1'b0;
            r_frame_len  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_line       <= w_line_nxt;
            r_fill       <= w_fill_nxt;
            r_crc        <= w_crc_nxt;
            r_len        <= w_len_nxt;
            r_m_valid    <= w_m_valid_nxt;
            r_m_last     <= w_m_last_nxt;
            r_m_data     <= w_m_data_nxt;
            r_stat_valid <= w_stat_valid_nxt;
            r_crc_ok     <= w_crc_ok_nxt;
            r_len_err    <= w_len_err_nxt;
            r_abort      <= w_abort_nxt;
            r_frame_len  <= w_frame_len_nxt;
        end
    end

    assign m_valid_o      = r_m_valid;
    assign m_last_o       = r_m_last;
    assign m_data_o       = r_m_data;
    assign status_valid_o = r_stat_valid;
    assign crc_ok_o       = r_crc_ok;
    assign len_err_o      = r_len_err;
    assign abort_o        = r_abort;
    assign frame_len_o    = r_frame_len;

`ifdef CRC_FRAME_CHECK_STATS_EN
    logic [31:0] r_stat_good, r_stat_bad, r_stat_len, r_stat_abort;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stat_good  <= '0;
            r_stat_bad   <= '0;
            r_stat_len   <= '0;
            r_stat_abort <= '0;
        end else if (r_stat_valid) begin
            if (r_crc_ok) begin
                r_stat_good <= r_stat_good + 32'd1;
            end
            if (!r_crc_ok && !r_len_err && !r_abort) begin
                r_stat_bad <= r_stat_bad + 32'd1;
            end
            if (r_len_err) begin
                r_stat_len <= r_stat_len + 32'd1;
            end
            if (r_abort) begin
                r_stat_abort <= r_stat_abort + 32'd1;
            end
        end
    end

    assign stat_good_o  = r_stat_good;
    assign stat_bad_o   = r_stat_bad;
    assign stat_len_o   = r_stat_len;
    assign stat_abort_o = r_stat_abort;
`endif

endmodule

// File: tb/tb_crc_frame_check.sv
// Directed bench for crc_frame_check using CRC-16/MAXIM frames ("123456789" -> 0x44C2).
module tb_crc_frame_check;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        soft_reset_i = 1'b0;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic [7:0]  s_data_i = 8'h00;
    logic        s_sop_i = 1'b0;
    logic        s_eop_i = 1'b0;
    logic        m_valid_o;
    logic        m_ready_i = 1'b1;
    logic [7:0]  m_data_o;
    logic        m_last_o;
    logic        status_valid_o;
    logic        crc_ok_o;
    logic        len_err_o;
    logic        abort_o;
    logic [15:0] frame_len_o;
`ifdef CRC_FRAME_CHECK_STATS_EN
    logic [31:0] stat_good_o, stat_bad_o, stat_len_o, stat_abort_o;
`endif

    crc_frame_check u_dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .soft_reset_i   (soft_reset_i),
        .s_valid_i      (s_valid_i),
        .s_ready_o      (s_ready_o),
        .s_data_i       (s_data_i),
        .s_sop_i        (s_sop_i),
        .s_eop_i        (s_eop_i),
        .m_valid_o      (m_valid_o),
        .m_ready_i      (m_ready_i),
        .m_data_o       (m_data_o),
        .m_last_o       (m_last_o),
        .status_valid_o (status_valid_o),
        .crc_ok_o       (crc_ok_o),
        .len_err_o      (len_err_o),
        .abort_o        (abort_o),
`ifdef CRC_FRAME_CHECK_STATS_EN
        .stat_good_o    (stat_good_o),
        .stat_bad_o     (stat_bad_o),
        .stat_len_o     (stat_len_o),
        .stat_abort_o   (stat_abort_o),
`endif
        .frame_len_o    (frame_len_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          ok;
        bit          lerr;
        bit          abrt;
        logic [15:0] len;
        bit          with_last;
    } stat_t;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  out_q[$];
    bit          last_q[$];
    stat_t       stat_q[$];
    int          stall_viol = 0;
    bit          tog_en = 1'b0;

    logic [7:0]  good[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                             8'hC2, 8'h44};
    logic [7:0]  bad[$];
    logic [7:0]  exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk_i) begin
        #1;
        m_ready_i = tog_en ? ~m_ready_i : 1'b1;
    end

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (m_valid_o && m_ready_i) begin
                out_q.push_back(m_data_o);
                last_q.push_back(m_last_o);
            end
            if (status_valid_o) begin
                stat_q.push_back('{crc_ok_o, len_err_o, abort_o, frame_len_o,
                                   m_valid_o && m_last_o});
            end
            if (m_valid_o && !m_ready_i && s_ready_o) begin
                stall_viol++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic sop, input logic eop);
        bit acc;
        int budget;
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_sop_i   = sop;
        s_eop_i   = eop;
        acc       = 1'b0;
        budget    = 50;
        while (!acc && budget > 0) begin
            @(negedge clk_i);
            acc = s_ready_o;
            @(posedge clk_i);
            #1;
            budget--;
        end
        if (!acc) check_eq("accept_timeout", 64'(acc), 64'd1);
        s_valid_i = 1'b0;
        s_sop_i   = 1'b0;
        s_eop_i   = 1'b0;
    endtask

    // Sends the first n bytes of fr; eop on the last one only if with_eop.
    task automatic send_seq(input logic [7:0] fr[$], input int n, input bit with_eop);
        for (int i = 0; i < n; i++) begin
            send_byte(fr[i], i == 0, with_eop && (i == n - 1));
        end
    endtask

    task automatic settle();
        repeat (6) @(posedge clk_i);
        #1;
    endtask

    task automatic clear_logs();
        out_q.delete();
        last_q.delete();
        stat_q.delete();
        stall_viol = 0;
    endtask

    task automatic check_out(input string tag, input logic [7:0] exp[$], input int last_idx);
        check_eq({tag, "_count"}, 64'(out_q.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < out_q.size(); i++) begin
            check_eq($sformatf("%s_byte%0d", tag, i), 64'(out_q[i]), 64'(exp[i]));
            check_eq($sformatf("%s_last%0d", tag, i), 64'(last_q[i]), 64'(i == last_idx));
        end
    endtask

    task automatic check_stat(input string tag, input int idx, input bit ok, input bit lerr,
                              input bit abrt, input logic [15:0] len, input bit chk_len);
        if (idx >= stat_q.size()) begin
            check_eq({tag, "_present"}, 64'(stat_q.size()), 64'(idx + 1));
        end else begin
            check_eq({tag, "_ok"}, 64'(stat_q[idx].ok), 64'(ok));
            check_eq({tag, "_len_err"}, 64'(stat_q[idx].lerr), 64'(lerr));
            check_eq({tag, "_abort"}, 64'(stat_q[idx].abrt), 64'(abrt));
            if (chk_len) check_eq({tag, "_len"}, 64'(stat_q[idx].len), 64'(len));
            if (!lerr && !abrt) check_eq({tag, "_with_last"}, 64'(stat_q[idx].with_last), 64'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        exp_q = good[0:8];
        bad   = good;
        bad[2] = 8'h34;

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_m_valid", 64'(m_valid_o), 64'd0);
        check_eq("rst_m_last", 64'(m_last_o), 64'd0);
        check_eq("rst_m_data", 64'(m_data_o), 64'd0);
        check_eq("rst_status_valid", 64'(status_valid_o), 64'd0);
        check_eq("rst_crc_ok", 64'(crc_ok_o), 64'd0);
        check_eq("rst_len_err", 64'(len_err_o), 64'd0);
        check_eq("rst_abort", 64'(abort_o), 64'd0);
        check_eq("rst_frame_len", 64'(frame_len_o), 64'd0);
        check_eq("rst_s_ready", 64'(s_ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Good frame, ready held high
        clear_logs();
        send_seq(good, 11, 1'b1);
        settle();
        check_out("good", exp_q, 8);
        check_eq("good_nstat", 64'(stat_q.size()), 64'd1);
        check_stat("good", 0, 1'b1, 1'b0, 1'b0, 16'd9, 1'b1);

        // Corrupted payload byte
        clear_logs();
        send_seq(bad, 11, 1'b1);
        settle();
        check_out("bad", bad[0:8], 8);
        check_stat("bad", 0, 1'b0, 1'b0, 1'b0, 16'd9, 1'b1);

        // Short frames: 2 bytes, then sop=eop single byte
        clear_logs();
        send_seq('{8'hAA, 8'hBB}, 2, 1'b1);
        send_seq('{8'hCC}, 1, 1'b1);
        settle();
        check_eq("short_out_count", 64'(out_q.size()), 64'd0);
        check_eq("short_nstat", 64'(stat_q.size()), 64'd2);
        check_stat("short2", 0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1);
        check_stat("short1", 1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1);

        // Downstream backpressure
        clear_logs();
        tog_en = 1'b1;
        send_seq(good, 11, 1'b1);
        settle();
        tog_en = 1'b0;
        settle();
        check_out("bp", exp_q, 8);
        check_stat("bp", 0, 1'b1, 1'b0, 1'b0, 16'd9, 1'b1);
        check_eq("bp_ready_stall", 64'(stall_viol), 64'd0);

        // Abort after 5 bytes, then a good frame
        clear_logs();
        send_seq(good, 5, 1'b0);
        send_seq(good, 11, 1'b1);
        settle();
        check_out("abort", {good[0:2], exp_q}, 11);
        check_eq("abort_nstat", 64'(stat_q.size()), 64'd2);
        check_stat("abort_old", 0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0);
        check_stat("abort_new", 1, 1'b1, 1'b0, 1'b0, 16'd9, 1'b1);

        // Soft reset mid-frame: no status, following frame checks
        clear_logs();
        send_seq(good, 6, 1'b0);
        soft_reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        soft_reset_i = 1'b0;
        settle();
        check_eq("soft_nstat", 64'(stat_q.size()), 64'd0);
        send_seq(good, 11, 1'b1);
        settle();
        check_out("soft", {good[0:3], exp_q}, 12);
        check_stat("soft", 0, 1'b1, 1'b0, 1'b0, 16'd9, 1'b1);

        // Hard reset mid-stream
        send_seq(good, 6, 1'b0);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check_eq("hrst_m_valid", 64'(m_valid_o), 64'd0);
        check_eq("hrst_m_last", 64'(m_last_o), 64'd0);
        check_eq("hrst_m_data", 64'(m_data_o), 64'd0);
        check_eq("hrst_status", 64'({status_valid_o, crc_ok_o, len_err_o, abort_o}), 64'd0);
        check_eq("hrst_frame_len", 64'(frame_len_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        clear_logs();
        @(posedge clk_i);
        #1;
        send_seq(good, 11, 1'b1);
        settle();
        check_out("hrst", exp_q, 8);
        check_stat("hrst", 0, 1'b1, 1'b0, 1'b0, 16'd9, 1'b1);
`ifdef CRC_FRAME_CHECK_STATS_EN
        check_eq("stat_good", 64'(stat_good_o), 64'd1);
        check_eq("stat_bad", 64'(stat_bad_o), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
